// File: rtl/pwm_peripheral.sv
// 16-channel PWM generator: one shared prescaled 8-bit period counter and a
// period-synchronous duty shadow, so each period carries a single duty value.
module pwm_peripheral #(
   parameter int unsigned PRESCALE = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] out,
   output logic        period_start
);

   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   logic [15:0] r_pre_cnt;
   logic [7:0]  r_pwm_cnt;
   logic [7:0]  r_duty_shadow;
   logic [15:0] r_out;
   logic        r_period_start;

   logic        w_tick;
   logic        w_boundary;
   logic        w_pwm_level;
   logic [15:0] w_en_out;
   logic [15:0] w_en_pwm;
   logic [15:0] w_out_next;

   assign w_tick     = (r_pre_cnt == PRE_LAST);
   assign w_boundary = w_tick && (r_pwm_cnt == 8'hFF);

   // 0xFF is pinned to full-on; a plain compare would leave one low count.
   assign w_pwm_level = (r_duty_shadow == 8'hFF) || (r_pwm_cnt < r_duty_shadow);

   assign w_en_out   = {en_reg_out_15_8, en_reg_out_7_0};
   assign w_en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
   assign w_out_next = w_en_out & (~w_en_pwm | {16{w_pwm_level}});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre_cnt      <= '0;
         r_pwm_cnt      <= '0;
         r_duty_shadow  <= '0;
         r_out          <= '0;
         r_period_start <= 1'b0;
      end else begin
         r_pre_cnt      <= w_tick ? 16'd0 : r_pre_cnt + 16'd1;
         if (w_tick)
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
         if (w_boundary)
            r_duty_shadow <= pwm_duty_cycle;
         r_out          <= w_out_next;
         r_period_start <= w_boundary;
      end
   end

   assign out          = r_out;
   assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: two instances (PRESCALE 1 and 4) checked every cycle
// against a time-based model, plus directed period measurements.
module tb_pwm_peripheral;

   logic        clk;
   logic        rst;
   logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
   logic [7:0]  pwm_duty_cycle;
   logic [15:0] out_p1, out_p4;
   logic        ps_p1, ps_p4;

   int n_tests = 0;
   int n_fail  = 0;
   int n_print = 0;

   pwm_peripheral #(.PRESCALE(1)) u_dut_p1 (
      .clk(clk), .rst(rst),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .out(out_p1), .period_start(ps_p1));

   pwm_peripheral #(.PRESCALE(4)) u_dut_p4 (
      .clk(clk), .rst(rst),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .out(out_p4), .period_start(ps_p4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: position in the period follows from the number of clocks since reset.
   int          m_t [2];
   logic [7:0]  m_sh [2];
   logic [15:0] exp_out [2];
   logic        exp_ps [2];
   logic        m_valid = 1'b0;
   logic [15:0] m_en_o, m_en_p, m_act_out;
   logic        m_lvl, m_act_ps;
   int          m_p, m_pre, m_cnt;

   initial begin
      forever begin
         @(posedge clk);
         m_en_o = {en_reg_out_15_8, en_reg_out_7_0};
         m_en_p = {en_reg_pwm_15_8, en_reg_pwm_7_0};
         for (int k = 0; k < 2; k++) begin
            m_p = (k == 0) ? 1 : 4;
            if (rst) begin
               m_t[k] = 0; m_sh[k] = 8'h00; exp_out[k] = 16'h0000; exp_ps[k] = 1'b0;
            end else begin
               m_pre = m_t[k] % m_p;
               m_cnt = (m_t[k] / m_p) % 256;
               m_lvl = (m_sh[k] == 8'hFF) ? 1'b1 : (m_cnt < int'(m_sh[k]));
               for (int i = 0; i < 16; i++) begin
                  if (!m_en_o[i])      exp_out[k][i] = 1'b0;
                  else if (!m_en_p[i]) exp_out[k][i] = 1'b1;
                  else                 exp_out[k][i] = m_lvl;
               end
               exp_ps[k] = (m_pre == m_p - 1) && (m_cnt == 255);
               if (exp_ps[k]) m_sh[k] = pwm_duty_cycle;
               m_t[k] = m_t[k] + 1;
            end
         end
         m_valid = 1'b1;
         #1;
         for (int k = 0; k < 2; k++) begin
            m_act_out = (k == 0) ? out_p1 : out_p4;
            m_act_ps  = (k == 0) ? ps_p1 : ps_p4;
            n_tests += 2;
            if (m_act_out !== exp_out[k]) begin
               n_fail++;
               if (n_print < 30) $display("FAIL cycle_out[%0d] t=%0t got %h expected %h", k, $time, m_act_out, exp_out[k]);
               n_print++;
            end
            if (m_act_ps !== exp_ps[k]) begin
               n_fail++;
               if (n_print < 30) $display("FAIL cycle_period_start[%0d] t=%0t got %b expected %b", k, $time, m_act_ps, exp_ps[k]);
               n_print++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_ps(input int which, input int budget);
      for (int n = 0; n < budget; n++) begin
         tick();
         if ((which == 0) ? ps_p1 : ps_p4) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL wait_period_start[%0d] timed out after %0d cycles", which, budget);
   endtask

   task automatic count_highs(output int h_dut, output int h_model);
      h_dut = 0;
      h_model = 0;
      for (int n = 0; n < 256; n++) begin
         tick();
         h_dut   += int'(out_p1[0]);
         h_model += int'(exp_out[0][0]);
      end
   endtask

   logic [7:0] duties [5]  = '{8'h00, 8'h01, 8'h80, 8'hFE, 8'hFF};
   int         highs  [5]  = '{0, 1, 128, 254, 256};
   int         hd, hm, h1, h2, n;
   logic       early_high;
   logic [7:0] v;

   initial begin
      rst = 1'b1;
      en_reg_out_7_0 = 8'h00; en_reg_out_15_8 = 8'h00;
      en_reg_pwm_7_0 = 8'h00; en_reg_pwm_15_8 = 8'h00;
      pwm_duty_cycle = 8'h00;
      repeat (3) tick();
      check("reset_out", {16'h0, out_p1}, 32'h0);
      check("reset_period_start", {31'h0, ps_p1}, 32'h0);
      rst = 1'b0;

      // Static mode
      en_reg_out_7_0 = 8'hA5;
      tick();
      check("static_a5", {16'h0, out_p1}, 32'h00A5);
      check("static_a5_model", {16'h0, exp_out[0]}, 32'h00A5);
      en_reg_out_7_0 = 8'h00;
      tick();
      check("static_off", {16'h0, out_p1}, 32'h0000);

      // Duty sweep on channel 0
      en_reg_out_7_0 = 8'h01; en_reg_pwm_7_0 = 8'h01;
      for (int d = 0; d < 5; d++) begin
         pwm_duty_cycle = duties[d];
         wait_ps(0, 600);
         wait_ps(0, 600);
         count_highs(hd, hm);
         check($sformatf("sweep_highs_%02h", duties[d]), hd, highs[d]);
         check($sformatf("sweep_model_%02h", duties[d]), hm, highs[d]);
      end

      // Shadow timing: duty change in mid-period waits for the next period
      pwm_duty_cycle = 8'h40;
      wait_ps(0, 600);
      wait_ps(0, 600);
      h1 = 0; h2 = 0;
      for (int k = 1; k <= 512; k++) begin
         tick();
         if (k <= 256) h1 += int'(out_p1[0]);
         else          h2 += int'(out_p1[0]);
         if (k == 100) pwm_duty_cycle = 8'hC0;
         if (k == 256) check("shadow_next_period_start", {31'h0, ps_p1}, 32'h1);
      end
      check("shadow_current_period", h1, 64);
      check("shadow_next_period", h2, 192);

      // Prescaler 4 instance
      pwm_duty_cycle = 8'h80;
      en_reg_out_15_8 = 8'h80; en_reg_pwm_15_8 = 8'h80;
      wait_ps(1, 2100);
      n = 0; h1 = 0;
      for (int k = 0; k < 1100; k++) begin
         tick();
         n++;
         h1 += int'(out_p4[15]);
         if (ps_p4) break;
      end
      check("prescale_period_len", n, 1024);
      check("prescale_out15_highs", h1, 512);
      en_reg_out_15_8 = 8'h00; en_reg_pwm_15_8 = 8'h00;

      // Mid-period reset
      en_reg_out_7_0 = 8'h03; en_reg_pwm_7_0 = 8'h01;
      wait_ps(0, 600);
      repeat (50) tick();
      rst = 1'b1;
      tick();
      check("midreset_out", {16'h0, out_p1}, 32'h0);
      check("midreset_period_start", {31'h0, ps_p1}, 32'h0);
      rst = 1'b0;
      n = 0; early_high = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick();
         n++;
         if (n == 1) check("midreset_static_ch1", {31'h0, out_p1[1]}, 32'h1);
         if (out_p1[0]) early_high = 1'b1;
         if (ps_p1) break;
      end
      check("midreset_first_boundary", n, 256);
      check("midreset_pwm_low_until_boundary", {31'h0, early_high}, 32'h0);
      count_highs(hd, hm);
      check("midreset_first_period_highs", hd, 128);

      // Enable override with full duty on every channel
      pwm_duty_cycle = 8'hFF;
      en_reg_pwm_7_0 = 8'hFF; en_reg_pwm_15_8 = 8'hFF;
      en_reg_out_7_0 = 8'hFF; en_reg_out_15_8 = 8'hFF;
      wait_ps(0, 600);
      for (int j = 0; j < 12; j++) begin
         v = (j % 2 == 1) ? 8'h00 : 8'hFF;
         en_reg_out_15_8 = v;
         tick();
         check("override_hi", {24'h0, out_p1[15:8]}, {24'h0, v});
         check("override_lo", {24'h0, out_p1[7:0]}, 32'hFF);
      end

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(15, 0) == 0) begin
            en_reg_out_7_0  = 8'($urandom); en_reg_out_15_8 = 8'($urandom);
            en_reg_pwm_7_0  = 8'($urandom); en_reg_pwm_15_8 = 8'($urandom);
         end
         if ($urandom_range(63, 0) == 0) begin
            case ($urandom_range(3, 0))
               0:       pwm_duty_cycle = 8'h00;
               1:       pwm_duty_cycle = 8'hFF;
               default: pwm_duty_cycle = 8'($urandom);
            endcase
         end
         rst = ($urandom_range(1999, 0) == 0);
         tick();
      end
      rst = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
